// File: rtl/elastic_pipe.sv
// Valid/ready pipeline register built from DEPTH chained two-entry skid stages.
// Optional stall counter output enabled by defining ELASTIC_PIPE_STALLCNT_EN.
module elastic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int CW    = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
`ifdef ELASTIC_PIPE_STALLCNT_EN
   ,output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Link k is the handshake into stage k; link DEPTH faces downstream.
    logic [DEPTH:0]            link_valid;
    logic [DEPTH:0]            link_ready;
    logic [DEPTH:0][WIDTH-1:0] link_data;

    assign link_valid[0]     = in_valid;
    assign link_data[0]      = in_data;
    assign link_ready[DEPTH] = out_ready;

    assign in_ready  = link_ready[0];
    assign out_valid = link_valid[DEPTH];
    assign out_data  = link_data[DEPTH];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            stage_state_t     state;
            stage_state_t     state_nxt;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;
            logic             push;
            logic             pop;

            assign push = link_valid[k] && ready_q;
            assign pop  = (state != ST_EMPTY) && link_ready[k+1];

            assign link_ready[k]  = ready_q;
            assign link_valid[k+1] = (state != ST_EMPTY);
            assign link_data[k+1]  = main_q;

            // NOTE: every variable written here gets a default first so no latch is inferred.
            always_comb begin
                state_nxt = state;
                case (state)
                    ST_EMPTY: if (push) state_nxt = ST_ONE;
                    ST_ONE: begin
                        if (push && !pop)      state_nxt = ST_FULL;
                        else if (pop && !push) state_nxt = ST_EMPTY;
                    end
                    ST_FULL:  if (pop) state_nxt = ST_ONE;
                    default:  state_nxt = ST_EMPTY;
                endcase
            end

            // NOTE: sequential state uses non-blocking assignments only, so stages
            // chained in the same edge all see each other's pre-edge values.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state   <= ST_EMPTY;
                    // NOTE: payload registers are reset so out_data reads 0 after reset/flush.
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                end else if (flush) begin
                    state   <= ST_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                end else begin
                    state   <= state_nxt;
                    ready_q <= (state_nxt != ST_FULL);
                    case (state)
                        ST_EMPTY: if (push) main_q <= link_data[k];
                        ST_ONE: begin
                            if (push && !pop)     skid_q <= link_data[k];
                            else if (push && pop) main_q <= link_data[k];
                        end
                        ST_FULL:  if (pop) main_q <= skid_q;
                        default:  ;
                    endcase
                end
            end
        end
    endgenerate

    // Internal stage-to-stage moves conserve entries, so occupancy only
    // changes on the two outer handshakes.
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

`ifdef ELASTIC_PIPE_STALLCNT_EN
    // Saturating count of cycles downstream held off valid data; survives flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard testbench for elastic_pipe: a reference FIFO queue models contents,
// a monitor pops and compares on every output transfer.
module tb_elastic_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(2*DEPTH+1);

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
`ifdef ELASTIC_PIPE_STALLCNT_EN
    logic [31:0]      stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             stall_pend = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;

    elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef ELASTIC_PIPE_STALLCNT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue side: every accepted input becomes an expected output.
    always @(negedge clk) begin
        if (!reset && !flush && in_valid && in_ready)
            exp_q.push_back(in_data);
    end

    // Monitor: compares each delivered word and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid_held", out_valid, 1'b1);
                check("stall_data_held", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("out_data_order", out_data, exp_q.pop_front());
                end
            end
            stall_pend = out_valid && !out_ready && !flush;
            stall_data = out_data;
            if (flush) exp_q.delete();
        end
    end

    // Occupancy must always equal accepted minus delivered.
    always @(posedge clk) begin
        #2;
        if (!reset) check("count_vs_model", count, exp_q.size());
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8*DEPTH + 8 && (exp_q.size() != 0 || out_valid); i++) tick();
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #10;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_count", count, 0);
        tick();
        reset = 1'b0;
        tick();

        // Streaming: first output DEPTH-1 edges after the first accept, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 16 + DEPTH; i++) begin
            if (i < 16) begin
                in_valid = 1'b1;
                in_data  = WIDTH'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("stream_out_valid", out_valid, (i >= DEPTH - 1) && (i <= DEPTH + 14));
        end
        check("stream_drained", exp_q.size(), 0);

        // Full backpressure: exactly 2*DEPTH words accepted
        begin
            int acc;
            acc       = 0;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            for (int i = 0; i < 4*DEPTH + 4; i++) begin
                if (!in_ready) break;
                in_data = 32'hA0 + WIDTH'(acc);
                tick();
                acc++;
            end
            check("bp_accepted", acc, 2*DEPTH);
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_count_full", count, 2*DEPTH);
            in_data = 32'h0000_0BAD;
            repeat (3) tick();
            check("bp_count_held", count, 2*DEPTH);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                tick();
                check("bp_in_ready_return", in_ready, j == DEPTH - 1);
            end
            drain();
        end

        // Flush with a concurrent input that must be dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h100 + WIDTH'(i);
            tick();
        end
        check("flush_pre_count", count, 3);
        flush   = 1'b1;
        in_data = 32'hDEAD;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_out_data", out_data, 0);
        check("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (2*DEPTH + 2) tick();
        check("flush_nothing_delivered", out_valid, 1'b0);

        // Random interleave with rare flushes
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 255) == 0);
            tick();
        end
        flush = 1'b0;
        drain();

        // Reset mid-stream with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h200 + WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_pre_count", count, 2);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_count", count, 0);
        tick();
        reset = 1'b0;
        tick();

`ifdef ELASTIC_PIPE_STALLCNT_EN
        // Stall counter: five held cycles then a pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4*DEPTH && !out_valid; i++) tick();
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_cnt_start", stall_cnt, 0);
        repeat (5) tick();
        check("stall_cnt_five", stall_cnt, 5);
        out_ready = 1'b1;
        tick();
        check("stall_cnt_after_pop", stall_cnt, 5);
`endif

        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
